// File: rtl/input_port_if.sv
// Bundle of the producer handshake and processor load-path signals of the input port.
// The master side is the producer/processor; the slave side is the port itself.
interface input_port_if #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic signed [WIDTH-1:0] ext_data;
   logic                    ext_valid;
   logic                    ext_ready;
   logic                    rd_en;
   logic signed [WIDTH-1:0] rd_data;
   logic                    empty;
   logic                    full;
   logic [CW-1:0]           count;
   logic                    underflow;
   logic                    clr_err;

   modport master (
      output ext_data, ext_valid, rd_en, clr_err,
      input  ext_ready, rd_data, empty, full, count, underflow
   );

   modport slave (
      input  ext_data, ext_valid, rd_en, clr_err,
      output ext_ready, rd_data, empty, full, count, underflow
   );
endinterface

// File: rtl/input_port.sv
// Memory-mapped input port: a small FIFO filled by an external producer and drained
// one word per processor load, with the head word presented combinationally.
module input_port #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input logic         clk,
   input logic         reset,
   input_port_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic signed [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]           r_wptr;
   logic [AW-1:0]           r_rptr;
   logic [CW-1:0]           r_count;
   logic                    r_underflow;

   logic w_empty;
   logic w_full;
   logic w_ready;
   logic w_push;
   logic w_pop;

   // A full FIFO refuses pushes even when a pop happens on the same edge.
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_ready = !w_full && !reset;
   assign w_push  = bus.ext_valid && w_ready;
   assign w_pop   = bus.rd_en && !w_empty;

   assign bus.ext_ready = w_ready;
   assign bus.empty     = w_empty;
   assign bus.full      = w_full;
   assign bus.count     = r_count;
   assign bus.underflow = r_underflow;
   assign bus.rd_data   = w_empty ? '0 : r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= bus.ext_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_underflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         // A read of an empty port wins over a same-cycle clear.
         if (bus.rd_en && w_empty) begin
            r_underflow <= 1'b1;
         end else if (bus.clr_err) begin
            r_underflow <= 1'b0;
         end
      end
   end
endmodule
